character_renderer: RTL and testbench

// Consumer side of the character position interface. Takes the character's top-left position
// (out_x/out_y of the movement block) and the VGA scan coordinates. Emits the character

---
 rtl/game_pkg.sv | 37 +++
 rtl/character_renderer_if.sv | 39 +++
 rtl/character_sprite_rom.sv | 15 +
 rtl/character_renderer.sv | 138 +++++++++++++
 tb/tb_character_renderer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared game constants: screen size, character reset position,
// blink state encoding, colour palette and the sprite bitmap.
package game_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int CHAR_RESET_X = 328;
  localparam int CHAR_RESET_Y = 232;

  typedef enum logic [1:0] {
    SHOW      = 2'd0,
    BLINK_ON  = 2'd1,
    BLINK_OFF = 2'd2
  } blink_e;

  localparam logic [23:0] PALETTE [16] = '{
    24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00,
    24'h0000FF, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF,
    24'h808080, 24'h800000, 24'h008000, 24'h000080,
    24'hFF8000, 24'h8000FF, 24'hC0C0C0, 24'h404040
  };

  // Sprite bitmap as a constant table: address is {row,col}.
  // The anti-diagonal is transparent; elsewhere index = 3*row+col+5.
  function automatic logic [3:0] sprite_index(input logic [7:0] a);
    logic [3:0] r;
    logic [3:0] c;
    logic [4:0] s;
    r = a[7:4];
    c = a[3:0];
    s = {1'b0, r} + {1'b0, c};
    if (s == 5'd15) return 4'd0;
    return r + r + r + c + 4'd5;
  endfunction

endpackage

// File: rtl/character_renderer_if.sv
// Scan/position bundle between the video timing side and the
// character renderer: position, scan coords in, RGB out.
interface character_renderer_if;

  logic       game_state;
  logic       frame_start;
  logic [9:0] char_x;
  logic [9:0] char_y;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic [23:0] rgb_out;
  logic        rgb_valid;

  modport master (
    output game_state,
    output frame_start,
    output char_x,
    output char_y,
    output pixel_x,
    output pixel_y,
    output video_on,
    input  rgb_out,
    input  rgb_valid
  );

  modport slave (
    input  game_state,
    input  frame_start,
    input  char_x,
    input  char_y,
    input  pixel_x,
    input  pixel_y,
    input  video_on,
    output rgb_out,
    output rgb_valid
  );

endinterface

// File: rtl/character_sprite_rom.sv
// 256x4 sprite ROM, synchronous read, 1-cycle latency.
// Ports: clk, addr[7:0] = {row,col}, data[3:0] palette index.
module character_sprite_rom
  import game_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] addr,
  output logic [3:0] data
);

  always_ff @(posedge clk) begin
    data <= sprite_index(addr);
  end

endmodule

// File: rtl/character_renderer.sv
// Draws the character sprite over the background with 2-cycle latency.
// Ports: CLOCK_50, reset (async, low), bus (slave: scan in, rgb out).
module character_renderer
  import game_pkg::*;
#(
  parameter int          SPRITE_W     = 16,
  parameter int          SPRITE_H     = 16,
  parameter int          BLINK_FRAMES = 15,
  parameter logic [23:0] BG_RGB       = 24'h000000
) (
  input logic            CLOCK_50,
  input logic            reset,
  character_renderer_if.slave bus
);

  localparam int XW = $clog2(SPRITE_W);
  localparam int YW = $clog2(SPRITE_H);
  localparam int AW = XW + YW;
  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Shadow position, refreshed only at frame start so no tearing.
  logic [9:0] sx_q;
  logic [9:0] sy_q;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      sx_q <= 10'(CHAR_RESET_X);
      sy_q <= 10'(CHAR_RESET_Y);
    end else if (bus.frame_start) begin
      sx_q <= bus.char_x;
      sy_q <= bus.char_y;
    end
  end

  blink_e         state_q;
  blink_e         state_d;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;
  logic           last;

  assign last = (cnt_q == CW'(BLINK_FRAMES - 1));

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= SHOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.frame_start) begin
      case (state_q)
        SHOW: begin
          if (bus.game_state) begin
            state_d = BLINK_OFF;
            cnt_d   = '0;
          end
        end
        BLINK_OFF, BLINK_ON: begin
          if (!bus.game_state) begin
            state_d = SHOW;
            cnt_d   = '0;
          end else if (last) begin
            state_d = (state_q == BLINK_OFF) ? BLINK_ON : BLINK_OFF;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = SHOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Stage 1: offset into sprite. 11-bit unsigned compare rejects
  // negative offsets, so nothing wraps to the left/top edge.
  logic [10:0] dx;
  logic [10:0] dy;
  logic        hit;
  logic [7:0]  addr;

  assign dx   = {1'b0, bus.pixel_x} - {1'b0, sx_q};
  assign dy   = {1'b0, bus.pixel_y} - {1'b0, sy_q};
  assign hit  = bus.video_on
              && (dx < 11'(SPRITE_W))
              && (dy < 11'(SPRITE_H));
  assign addr = 8'({dy[YW-1:0], dx[XW-1:0]});

  logic [3:0] idx;

  character_sprite_rom u_rom (
    .clk  (CLOCK_50),
    .addr (addr),
    .data (idx)
  );

  logic        hit_q;
  logic        von_q;
  logic [23:0] rgb_q;
  logic        valid_q;
  logic        visible;

  assign visible = (state_q != BLINK_OFF);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      hit_q   <= 1'b0;
      von_q   <= 1'b0;
      rgb_q   <= 24'h0;
      valid_q <= 1'b0;
    end else begin
      hit_q   <= hit;
      von_q   <= bus.video_on;
      valid_q <= von_q;
      if (!von_q)
        rgb_q <= 24'h0;
      else if (hit_q && visible && idx != 4'd0)
        rgb_q <= PALETTE[idx];
      else
        rgb_q <= BG_RGB;
    end
  end

  assign bus.rgb_out   = rgb_q;
  assign bus.rgb_valid = valid_q;

  logic [AW-1:0] unused_addr_w;
  assign unused_addr_w = AW'(0);

endmodule

// File: tb/tb_character_renderer.sv
// Randomised + directed bench for character_renderer against a
// frame-level reference model with its own palette/sprite tables.
module tb_character_renderer;

  localparam int          BF = 2;
  localparam logic [23:0] BG = 24'h102030;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  character_renderer_if bus ();

  character_renderer #(
    .BLINK_FRAMES (BF),
    .BG_RGB       (BG)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst_n),
    .bus      (bus)
  );

  logic [23:0] pal [16] = '{
    24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00,
    24'h0000FF, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF,
    24'h808080, 24'h800000, 24'h008000, 24'h000080,
    24'hFF8000, 24'h8000FF, 24'hC0C0C0, 24'h404040
  };

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int sx = 328;
  int sy = 232;
  bit blinking = 0;
  int m = 0;
  int cur_cx = 0;
  int cur_cy = 0;
  bit cur_gs = 0;

  logic [24:0] exp_q [$];
  string       tag_q [$];

  task automatic chk(string tag, logic [24:0] got, logic [24:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic int sprite_idx(int r, int c);
    if (r + c == 15) return 0;
    return (3 * r + c + 5) % 16;
  endfunction

  task automatic step(string tag, int px, int py, bit von, bit fs);
    bit          hit;
    int          idx;
    bit          vis;
    logic [24:0] e;
    @(negedge clk);
    bus.pixel_x     = 10'(px);
    bus.pixel_y     = 10'(py);
    bus.video_on    = von;
    bus.frame_start = fs;
    bus.char_x      = 10'(cur_cx);
    bus.char_y      = 10'(cur_cy);
    bus.game_state  = cur_gs;
    hit = von && px >= sx && px < sx + 16 && py >= sy && py < sy + 16;
    idx = hit ? sprite_idx(py - sy, px - sx) : 0;
    if (fs) begin
      sx = cur_cx;
      sy = cur_cy;
      if (!cur_gs) blinking = 0;
      else if (!blinking) begin
        blinking = 1;
        m = 0;
      end else m++;
    end
    vis = !blinking || ((m / BF) % 2 == 1);
    if (!von) e = 25'h0;
    else if (hit && vis && idx != 0) e = {1'b1, pal[idx]};
    else e = {1'b1, BG};
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (exp_q.size() == 2)
      chk(tag_q.pop_front(), {bus.rgb_valid, bus.rgb_out},
          exp_q.pop_front());
  endtask

  task automatic model_reset();
    sx = 328;
    sy = 232;
    blinking = 0;
    m = 0;
    exp_q.delete();
    tag_q.delete();
    exp_q.push_back(25'h0);
    tag_q.push_back("post_rst");
  endtask

  task automatic idle_inputs();
    bus.pixel_x     = '0;
    bus.pixel_y     = '0;
    bus.video_on    = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  initial begin
    int px;
    int py;
    idle_inputs();
    bus.char_x     = '0;
    bus.char_y     = '0;
    bus.game_state = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_state", {bus.rgb_valid, bus.rgb_out}, 25'h0);
    repeat (3) @(negedge clk);
    chk("reset_hold", {bus.rgb_valid, bus.rgb_out}, 25'h0);
    model_reset();
    rst_n = 1'b1;

    // shadow capture
    cur_cx = 100; cur_cy = 50;
    step("cap_fs", 0, 0, 0, 1);
    step("cap_hit", 100, 50, 1, 0);
    step("cap_left", 99, 50, 1, 0);
    step("cap_in", 105, 53, 1, 0);

    // no tearing
    cur_cx = 200;
    step("tear_old", 100, 50, 1, 0);
    step("tear_new_bg", 200, 50, 1, 0);
    step("tear_fs", 0, 0, 0, 1);
    step("tear_after_old", 100, 50, 1, 0);
    step("tear_after_new", 200, 50, 1, 0);

    // clipping
    cur_cx = 632; cur_cy = 0;
    step("clip_fs", 0, 0, 0, 1);
    step("clip_col7", 639, 0, 1, 0);
    step("clip_nowrap", 0, 0, 1, 0);
    step("clip_row", 639, 15, 1, 0);

    // transparency and valid gating
    cur_cx = 100; cur_cy = 50;
    step("tr_fs", 0, 0, 0, 1);
    step("transp", 115, 50, 1, 0);
    step("transp2", 108, 57, 1, 0);
    step("von_off", 100, 50, 0, 0);
    step("von_on", 101, 50, 1, 0);

    // blink
    cur_gs = 1;
    for (int f = 0; f < 7; f++) begin
      step("blink_fs", 0, 0, 0, 1);
      step("blink_px", 100, 50, 1, 0);
      step("blink_px2", 103, 52, 1, 0);
    end
    cur_gs = 0;
    step("blink_pend", 100, 50, 1, 0);
    step("unblink_fs", 0, 0, 0, 1);
    step("unblink_px", 100, 50, 1, 0);

    // async reset mid-scan
    step("pre_rst", 100, 50, 1, 0);
    step("pre_rst2", 101, 50, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {bus.rgb_valid, bus.rgb_out}, 25'h0);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    step("rst_shadow", 328, 232, 1, 0);
    step("rst_shadow2", 327, 232, 1, 0);
    step("rst_flush", 0, 0, 0, 0);

    // randomised scan
    for (int i = 0; i < 800; i++) begin
      bit fs;
      fs = ($urandom_range(29, 0) == 0);
      if (fs) begin
        if ($urandom_range(3, 0) == 0) begin
          cur_cx = int'($urandom_range(639, 620));
          cur_cy = int'($urandom_range(479, 460));
        end else begin
          cur_cx = int'($urandom_range(639, 0));
          cur_cy = int'($urandom_range(479, 0));
        end
        if ($urandom_range(3, 0) == 0) cur_gs = ~cur_gs;
      end
      if ($urandom_range(9, 0) == 0) begin
        px = int'($urandom_range(639, 0));
        py = int'($urandom_range(479, 0));
      end else begin
        px = sx - 4 + int'($urandom_range(23, 0));
        py = sy - 4 + int'($urandom_range(23, 0));
      end
      if (px < 0) px = 0;
      if (px > 639) px = 639;
      if (py < 0) py = 0;
      if (py > 479) py = 479;
      step("rand", px, py, $urandom_range(9, 0) != 0, fs);
    end

    step("drain", 0, 0, 0, 0);
    step("drain", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
